// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter_mod.
// Ports: master drives clr, enable, direction, step, load, load_val and flag_clr,
//        and reads count, ovf, unf and sticky_evt; slave is the counter side.
interface updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clr;
  logic             enable;
  logic             direction;
  logic [WIDTH-1:0] step;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             flag_clr;
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic             unf;
  logic             sticky_evt;

  modport master (
    output clr, enable, direction, step, load, load_val, flag_clr,
    input  count, ovf, unf, sticky_evt
  );

  modport slave (
    input  clr, enable, direction, step, load, load_val, flag_clr,
    output count, ovf, unf, sticky_evt
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with prescaler, wrap or saturate mode,
// sync clear, parallel load, overflow/underflow pulses and a sticky event flag.
// Ports: clk, rst (async, active-high); bus (slave) carries the controls
//        clr/load/enable/direction/step/load_val/flag_clr and the registered
//        outputs count/ovf/unf/sticky_evt.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  updown_counter_if.slave  bus
);

  localparam int unsigned    EW      = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_EXT = EW'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + EW'(1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             sticky_q, sticky_d;
  logic             tick_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   wrap_up_c;
  logic [WIDTH:0]   wrap_dn_c;

  // Prescaler: tick on the PRESCALE-th enabled cycle; clr/load restart it.
  if (PRESCALE > 1) begin : g_pre
    localparam int unsigned PW = $clog2(PRESCALE);
    logic [PW-1:0] pre_q;

    assign tick_c = bus.enable && !bus.clr && !bus.load &&
                    (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pre_q <= '0;
      end else if (bus.clr || bus.load) begin
        pre_q <= '0;
      end else if (bus.enable) begin
        pre_q <= tick_c ? '0 : pre_q + PW'(1);
      end
    end
  end else begin : g_nopre
    assign tick_c = bus.enable;
  end

  // Next count and event flags; priority clr > load > tick.
  always_comb begin
    count_d   = count_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    sum_c     = {1'b0, count_q} + {1'b0, bus.step};
    wrap_up_c = sum_c - MOD_EXT;
    // count + modulus fits in WIDTH+1 bits because count <= MAX_VAL < 2**WIDTH
    wrap_dn_c = {1'b0, count_q} + MOD_EXT - {1'b0, bus.step};

    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    end else if (tick_c) begin
      if (bus.direction) begin
        if (sum_c > MAX_EXT) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX_W : wrap_up_c[WIDTH-1:0];
        end else begin
          count_d = sum_c[WIDTH-1:0];
        end
      end else begin
        if (bus.step > count_q) begin
          unf_d   = 1'b1;
          count_d = SATURATE ? '0 : wrap_dn_c[WIDTH-1:0];
        end else begin
          count_d = count_q - bus.step;
        end
      end
    end

    // set wins over a simultaneous flag_clr
    sticky_d = (sticky_q && !bus.flag_clr) || ovf_d || unf_d;
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;
  assign bus.sticky_evt = sticky_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: four instances with different parameter sets,
// a per-cycle arithmetic reference model, and directed literal checks.
module tb_updown_counter_mod;

  localparam int unsigned NI = 4;

  // Instance parameter sets: 0 default, 1 mod-10 wrap, 2 saturate 0..200, 3 prescale 4 mod-100.
  function automatic int maxv(input int i);
    case (i)
      1: return 9;
      2: return 200;
      3: return 99;
      default: return 255;
    endcase
  endfunction
  function automatic bit satm(input int i);
    return (i == 2);
  endfunction
  function automatic int presc(input int i);
    return (i == 3) ? 4 : 1;
  endfunction

  logic clk;
  logic rst;
  logic       clr_a [NI];
  logic       en_a  [NI];
  logic       dir_a [NI];
  logic [7:0] step_a[NI];
  logic       ld_a  [NI];
  logic [7:0] lv_a  [NI];
  logic       fc_a  [NI];
  logic [7:0] cnt_a [NI];
  logic       ovf_a [NI];
  logic       unf_a [NI];
  logic       stk_a [NI];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    updown_counter_if #(.WIDTH(8)) bus ();
    updown_counter_mod #(
      .WIDTH(8), .MAX_VAL(maxv(g)), .SATURATE(satm(g)), .PRESCALE(presc(g))
    ) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign bus.clr       = clr_a[g];
    assign bus.enable    = en_a[g];
    assign bus.direction = dir_a[g];
    assign bus.step      = step_a[g];
    assign bus.load      = ld_a[g];
    assign bus.load_val  = lv_a[g];
    assign bus.flag_clr  = fc_a[g];
    assign cnt_a[g]      = bus.count;
    assign ovf_a[g]      = bus.ovf;
    assign unf_a[g]      = bus.unf;
    assign stk_a[g]      = bus.sticky_evt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state per instance.
  typedef struct packed {
    int   c;
    int   p;
    logic o;
    logic u;
    logic s;
  } mst_t;
  mst_t m [NI];

  // One clock of the counter rules, using plain integer arithmetic.
  function automatic mst_t model_step(input int i, input mst_t s);
    mst_t n;
    int   mx;
    int   st;
    bit   tick;
    n    = s;
    mx   = maxv(i);
    st   = int'(step_a[i]);
    tick = 1'b0;
    n.o  = 1'b0;
    n.u  = 1'b0;
    if (clr_a[i]) begin
      n.c = 0;
      n.p = 0;
    end else if (ld_a[i]) begin
      n.c = (int'(lv_a[i]) > mx) ? mx : int'(lv_a[i]);
      n.p = 0;
    end else if (en_a[i]) begin
      if (s.p + 1 >= presc(i)) begin
        n.p  = 0;
        tick = 1'b1;
      end else begin
        n.p = s.p + 1;
      end
    end
    if (tick) begin
      if (dir_a[i]) begin
        if (s.c + st > mx) begin
          n.o = 1'b1;
          n.c = satm(i) ? mx : (s.c + st) % (mx + 1);
        end else begin
          n.c = s.c + st;
        end
      end else begin
        if (st > s.c) begin
          n.u = 1'b1;
          n.c = satm(i) ? 0 : (s.c - st + mx + 1) % (mx + 1);
        end else begin
          n.c = s.c - st;
        end
      end
    end
    n.s = (s.s && !fc_a[i]) || n.o || n.u;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) m[i] <= '0;
      else     m[i] <= model_step(i, m[i]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model compare on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.count", i),  int'(cnt_a[i]), m[i].c);
      chk($sformatf("u%0d.ovf", i),    int'(ovf_a[i]), int'(m[i].o));
      chk($sformatf("u%0d.unf", i),    int'(unf_a[i]), int'(m[i].u));
      chk($sformatf("u%0d.sticky", i), int'(stk_a[i]), int'(m[i].s));
      chk($sformatf("u%0d.excl", i),   int'(ovf_a[i] & unf_a[i]), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int ovf_seen;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      clr_a[i] = 1'b0; en_a[i] = 1'b0; dir_a[i] = 1'b1; step_a[i] = 8'd0;
      ld_a[i]  = 1'b0; lv_a[i] = 8'd0; fc_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst.count%0d", i), int'(cnt_a[i]), 0);
      chk($sformatf("rst.sticky%0d", i), int'(stk_a[i]), 0);
    end

    // 1: free-running up count on the default counter
    en_a[0] = 1'b1; dir_a[0] = 1'b1; step_a[0] = 8'd1;
    ovf_seen = 0;
    for (int k = 1; k <= 300; k++) begin
      cyc();
      if (ovf_a[0]) ovf_seen++;
      if (k == 255) chk("t1.c255", int'(cnt_a[0]), 255);
      if (k == 256) begin
        chk("t1.wrap", int'(cnt_a[0]), 0);
        chk("t1.ovf", int'(ovf_a[0]), 1);
      end
    end
    chk("t1.end", int'(cnt_a[0]), 44);
    chk("t1.novf", ovf_seen, 1);
    chk("t1.sticky", int'(stk_a[0]), 1);

    // 2: clear, then count down through zero
    en_a[0] = 1'b0; clr_a[0] = 1'b1; fc_a[0] = 1'b1;
    cyc();
    chk("t2.clr", int'(cnt_a[0]), 0);
    chk("t2.fclr", int'(stk_a[0]), 0);
    clr_a[0] = 1'b0; fc_a[0] = 1'b0; en_a[0] = 1'b1; dir_a[0] = 1'b0;
    cyc();
    chk("t2.c", int'(cnt_a[0]), 255);
    chk("t2.unf", int'(unf_a[0]), 1);
    chk("t2.stk", int'(stk_a[0]), 1);
    en_a[0] = 1'b0;
    cyc();
    chk("t2.unf0", int'(unf_a[0]), 0);
    chk("t2.stkh", int'(stk_a[0]), 1);
    fc_a[0] = 1'b1;
    cyc();
    chk("t2.stk0", int'(stk_a[0]), 0);
    fc_a[0] = 1'b0;

    // 3: modulo-10 wrap, step 3
    en_a[1] = 1'b1; dir_a[1] = 1'b1; step_a[1] = 8'd3;
    cyc(); chk("t3.3", int'(cnt_a[1]), 3);
    cyc(); chk("t3.6", int'(cnt_a[1]), 6);
    cyc(); chk("t3.9", int'(cnt_a[1]), 9);
    cyc(); chk("t3.2", int'(cnt_a[1]), 2); chk("t3.ovf", int'(ovf_a[1]), 1);
    dir_a[1] = 1'b0;
    cyc(); chk("t3.dn9", int'(cnt_a[1]), 9); chk("t3.unf", int'(unf_a[1]), 1);
    en_a[1] = 1'b0;

    // 4: saturate at 200 / 0
    ld_a[2] = 1'b1; lv_a[2] = 8'd180;
    cyc(); chk("t4.ld", int'(cnt_a[2]), 180);
    ld_a[2] = 1'b0; en_a[2] = 1'b1; dir_a[2] = 1'b1; step_a[2] = 8'd50;
    cyc(); chk("t4.sat1", int'(cnt_a[2]), 200); chk("t4.ovf1", int'(ovf_a[2]), 1);
    cyc(); chk("t4.sat2", int'(cnt_a[2]), 200); chk("t4.ovf2", int'(ovf_a[2]), 1);
    en_a[2] = 1'b0; ld_a[2] = 1'b1; lv_a[2] = 8'd30;
    cyc(); chk("t4.ld30", int'(cnt_a[2]), 30);
    ld_a[2] = 1'b0; en_a[2] = 1'b1; dir_a[2] = 1'b0;
    cyc(); chk("t4.zero", int'(cnt_a[2]), 0); chk("t4.unf1", int'(unf_a[2]), 1);
    cyc(); chk("t4.zero2", int'(cnt_a[2]), 0); chk("t4.unf2", int'(unf_a[2]), 1);
    en_a[2] = 1'b0;

    // 5: prescale by 4 with gaps, then load restarts the prescaler
    dir_a[3] = 1'b1; step_a[3] = 8'd1;
    en_a[3] = 1'b1; cyc(); chk("t5.e1", int'(cnt_a[3]), 0);
    cyc(); chk("t5.e2", int'(cnt_a[3]), 0);
    en_a[3] = 1'b0; cyc(); chk("t5.hold", int'(cnt_a[3]), 0);
    en_a[3] = 1'b1; cyc(); chk("t5.e3", int'(cnt_a[3]), 0);
    cyc(); chk("t5.e4", int'(cnt_a[3]), 1);
    cyc(); cyc();
    ld_a[3] = 1'b1; lv_a[3] = 8'd250;
    cyc(); chk("t5.clamp", int'(cnt_a[3]), 99);
    ld_a[3] = 1'b0;
    cyc(); cyc(); cyc(); chk("t5.pre3", int'(cnt_a[3]), 99);
    cyc(); chk("t5.wrap", int'(cnt_a[3]), 0); chk("t5.ovf", int'(ovf_a[3]), 1);
    en_a[3] = 1'b0;

    // 6: priority clr > load > enable
    dir_a[0] = 1'b1; step_a[0] = 8'd1;
    clr_a[0] = 1'b1; ld_a[0] = 1'b1; en_a[0] = 1'b1; lv_a[0] = 8'd77;
    cyc(); chk("t6.clr", int'(cnt_a[0]), 0);
    clr_a[0] = 1'b0;
    cyc(); chk("t6.ld", int'(cnt_a[0]), 77);
    ld_a[0] = 1'b0;
    cyc(); cyc(); cyc(); chk("t6.run", int'(cnt_a[0]), 80);
    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1 chk("t6.arst", int'(cnt_a[0]), 0);
    chk("t6.arst3", int'(cnt_a[3]), 0);
    cyc();
    rst = 1'b0;
    cyc(); chk("t6.resume", int'(cnt_a[0]), 1);
    en_a[0] = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
